// File: rtl/prog_mem_loader_if.sv
// Fetch and byte-load bus between the CPU/UART side (master) and the loadable
// program memory (slave).
interface prog_mem_loader_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_en;
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  inst_valid;
    logic                  fault;
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  load_done;
    logic [ADDR_WIDTH:0]   load_count;

    modport master (
        output fetch_en, pc, rx_byte, rx_valid,
        input  instruction, inst_valid, fault, load_done, load_count
    );

    modport slave (
        input  fetch_en, pc, rx_byte, rx_valid,
        output instruction, inst_valid, fault, load_done, load_count
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Loadable program memory: registered instruction fetch in run mode, and
// little-endian byte-stream word assembly written from word 0 in load mode.
module prog_mem_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int LOAD_WORDS = 16384,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    prog_mem_loader_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [BCW-1:0]      LAST_LANE_C  = BCW'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] LOAD_WORDS_C = (ADDR_WIDTH + 1)'(LOAD_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_IDX_C   = (ADDR_WIDTH + 1)'(LOAD_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] ONE_C        = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  fetch_s;
    logic                  enter_load_s;
    logic                  take_byte_s;
    logic                  write_word_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] word_buf_r;
    logic [BCW-1:0]        byte_cnt_r;
    logic [ADDR_WIDTH:0]   load_count_r;
    logic                  load_done_r;
    logic [DATA_WIDTH-1:0] instruction_r;
    logic                  inst_valid_r;
    logic                  fault_r;

    // A fetch is illegal when misaligned or beyond the implemented word range.
    function automatic logic pc_fault(input logic [31:0] addr);
        logic [31:0] hi_v;
        hi_v = addr >> (ADDR_WIDTH + 2);
        return (addr[1:0] != 2'd0) || (hi_v != 32'd0);
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the mode sampled at an edge always wins.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mode) state_nxt_s = LOAD;
                else      state_nxt_s = IDLE;
            end
            LOAD: begin
                if (!mode)                                          state_nxt_s = IDLE;
                else if (write_word_s && (load_count_r == LAST_IDX_C)) state_nxt_s = DONE;
                else                                                state_nxt_s = LOAD;
            end
            DONE: begin
                if (mode) state_nxt_s = DONE;
                else      state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state control strobes for the fetch and load datapaths.
    always_comb begin
        fetch_s      = 1'b0;
        enter_load_s = 1'b0;
        take_byte_s  = 1'b0;
        write_word_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mode) enter_load_s = 1'b1;
                else      fetch_s      = bus.fetch_en;
            end
            LOAD: begin
                if (mode) begin
                    if (bus.rx_valid) begin
                        take_byte_s  = 1'b1;
                        write_word_s = (byte_cnt_r == LAST_LANE_C) && (load_count_r < LOAD_WORDS_C);
                    end else begin
                        take_byte_s  = 1'b0;
                        write_word_s = 1'b0;
                    end
                end else begin
                    fetch_s = bus.fetch_en;
                end
            end
            DONE: begin
                if (mode) fetch_s = 1'b0;
                else      fetch_s = bus.fetch_en;
            end
            default: fetch_s = 1'b0;
        endcase
    end

    // Merge the incoming byte into its lane of the partially assembled word.
    always_comb begin
        wdata_s = word_buf_r;
        wdata_s[{byte_cnt_r, 3'b000} +: 8] = bus.rx_byte;
    end

    // Byte lane counter, word buffer, word counter and completion flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_r   <= '0;
            word_buf_r   <= '0;
            load_count_r <= '0;
            load_done_r  <= 1'b0;
        end else if (enter_load_s) begin
            byte_cnt_r   <= '0;
            word_buf_r   <= '0;
            load_count_r <= '0;
            load_done_r  <= 1'b0;
        end else if (take_byte_s) begin
            if (write_word_s) begin
                byte_cnt_r   <= '0;
                load_count_r <= load_count_r + ONE_C;
                if (load_count_r == LAST_IDX_C) begin
                    load_done_r <= 1'b1;
                end
            end else begin
                byte_cnt_r <= byte_cnt_r + BCW'(1);
                word_buf_r <= wdata_s;
            end
        end else if ((state_r == LOAD) && !mode) begin
            // Leaving load mid-word drops the partial word.
            byte_cnt_r <= '0;
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (write_word_s && !reset) begin
            mem_r[load_count_r[ADDR_WIDTH-1:0]] <= wdata_s;
        end
    end

    // Registered fetch; faulting requests return zero without a memory read.
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction_r <= '0;
            inst_valid_r  <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            inst_valid_r <= fetch_s;
            if (fetch_s) begin
                if (pc_fault(bus.pc)) begin
                    fault_r       <= 1'b1;
                    instruction_r <= '0;
                end else begin
                    fault_r       <= 1'b0;
                    instruction_r <= mem_r[bus.pc[ADDR_WIDTH+1:2]];
                end
            end else begin
                fault_r <= 1'b0;
            end
        end
    end

    assign bus.instruction = instruction_r;
    assign bus.inst_valid  = inst_valid_r;
    assign bus.fault       = fault_r;
    assign bus.load_done   = load_done_r;
    assign bus.load_count  = load_count_r;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader with a 4-word load region.
module tb_prog_mem_loader;
    logic clock = 1'b0;
    logic reset;
    logic mode;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    prog_mem_loader_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

    prog_mem_loader #(.ADDR_WIDTH(14), .LOAD_WORDS(4), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .mode  (mode),
        .bus   (bus.slave)
    );

    logic [7:0] stream1 [16] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                                 8'h13, 8'h01, 8'h20, 8'h00, 8'hb3, 8'h01, 8'h31, 8'h00};
    logic [31:0] words1 [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h003101b3};
    logic [7:0] stream2 [16] = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hef, 8'hcd, 8'hab, 8'h89,
                                 8'h0d, 8'hf0, 8'had, 8'h0b, 8'hbe, 8'hba, 8'hfe, 8'hca};
    logic [31:0] words2 [4] = '{32'h01234567, 32'h89abcdef, 32'h0badf00d, 32'hcafebabe};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        bus.pc       = addr;
        bus.fetch_en = 1'b1;
        step();
        bus.fetch_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0;
        bus.fetch_en = 1'b0; bus.pc = 32'd0; bus.rx_byte = 8'd0; bus.rx_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({bus.instruction, bus.inst_valid, bus.fault, bus.load_done, bus.load_count} !== 50'd0) begin
            errors++;
            $display("FAIL reset_outputs got instr=%h v=%b f=%b done=%b cnt=%0d want all zero",
                     bus.instruction, bus.inst_valid, bus.fault, bus.load_done, bus.load_count);
        end
    endtask

    task automatic test_load();
        mode = 1'b1;
        step();
        for (int i = 0; i < 15; i++) send_byte(stream1[i]);
        checks++;
        if ({bus.load_done, bus.load_count} !== {1'b0, 15'd3}) begin
            errors++;
            $display("FAIL load_15th_byte got done=%b cnt=%0d want done=0 cnt=3", bus.load_done, bus.load_count);
        end
        send_byte(stream1[15]);
        checks++;
        if ({bus.load_done, bus.load_count} !== {1'b1, 15'd4}) begin
            errors++;
            $display("FAIL load_16th_byte got done=%b cnt=%0d want done=1 cnt=4", bus.load_done, bus.load_count);
        end
    endtask

    task automatic test_back_to_back(input logic [31:0] w0, input logic [31:0] w1,
                                     input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] exp [4];
        exp = '{w0, w1, w2, w3};
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pc = 32'(i * 4);
            step();
            checks++;
            if ({bus.instruction, bus.inst_valid, bus.fault} !== {exp[i], 2'b10}) begin
                errors++;
                $display("FAIL fetch_word%0d got instr=%h v=%b f=%b want instr=%h v=1 f=0",
                         i, bus.instruction, bus.inst_valid, bus.fault, exp[i]);
            end
        end
        bus.fetch_en = 1'b0;
        step();
        checks++;
        if ({bus.instruction, bus.inst_valid} !== {w3, 1'b0}) begin
            errors++;
            $display("FAIL fetch_idle_hold got instr=%h v=%b want instr=%h v=0", bus.instruction, bus.inst_valid, w3);
        end
    endtask

    task automatic test_fault();
        fetch(32'h0000_0002);
        checks++;
        if ({bus.instruction, bus.inst_valid, bus.fault} !== {32'd0, 2'b11}) begin
            errors++;
            $display("FAIL fault_misaligned got instr=%h v=%b f=%b want instr=0 v=1 f=1",
                     bus.instruction, bus.inst_valid, bus.fault);
        end
        fetch(32'h0001_0000);
        checks++;
        if ({bus.instruction, bus.inst_valid, bus.fault} !== {32'd0, 2'b11}) begin
            errors++;
            $display("FAIL fault_range got instr=%h v=%b f=%b want instr=0 v=1 f=1",
                     bus.instruction, bus.inst_valid, bus.fault);
        end
        fetch(32'h0000_0008);
        checks++;
        if ({bus.instruction, bus.inst_valid, bus.fault} !== {32'h00200113, 2'b10}) begin
            errors++;
            $display("FAIL fault_clear got instr=%h v=%b f=%b want instr=00200113 v=1 f=0",
                     bus.instruction, bus.inst_valid, bus.fault);
        end
    endtask

    task automatic test_partial_abort();
        mode = 1'b1;
        bus.pc = 32'd0;
        bus.fetch_en = 1'b1;
        step();
        bus.fetch_en = 1'b0;
        checks++;
        if ({bus.inst_valid, bus.load_done, bus.load_count} !== {2'b00, 15'd0}) begin
            errors++;
            $display("FAIL load_entry got v=%b done=%b cnt=%0d want v=0 done=0 cnt=0",
                     bus.inst_valid, bus.load_done, bus.load_count);
        end
        send_byte(8'hef); send_byte(8'hbe); send_byte(8'had); send_byte(8'hde);
        send_byte(8'h11); send_byte(8'h22);
        mode = 1'b0;
        step();
        checks++;
        if ({bus.load_done, bus.load_count} !== {1'b0, 15'd1}) begin
            errors++;
            $display("FAIL abort_count got done=%b cnt=%0d want done=0 cnt=1", bus.load_done, bus.load_count);
        end
        fetch(32'd0);
        checks++;
        if (bus.instruction !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL abort_word0 got %h want deadbeef", bus.instruction);
        end
        fetch(32'd4);
        checks++;
        if (bus.instruction !== 32'h00100093) begin
            errors++;
            $display("FAIL abort_word1_kept got %h want 00100093", bus.instruction);
        end
        mode = 1'b1;
        step();
        checks++;
        if ({bus.load_done, bus.load_count} !== {1'b0, 15'd0}) begin
            errors++;
            $display("FAIL reentry_clear got done=%b cnt=%0d want done=0 cnt=0", bus.load_done, bus.load_count);
        end
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < 16; i++) send_byte(stream2[i]);
        send_byte(8'hff); send_byte(8'hff); send_byte(8'hff);
        checks++;
        if ({bus.load_done, bus.load_count} !== {1'b1, 15'd4}) begin
            errors++;
            $display("FAIL done_extra_bytes got done=%b cnt=%0d want done=1 cnt=4", bus.load_done, bus.load_count);
        end
        mode = 1'b0;
        step();
        send_byte(8'h77); send_byte(8'h77);
        checks++;
        if ({bus.load_done, bus.load_count} !== {1'b1, 15'd4}) begin
            errors++;
            $display("FAIL idle_rx_ignored got done=%b cnt=%0d want done=1 cnt=4", bus.load_done, bus.load_count);
        end
        test_back_to_back(words2[0], words2[1], words2[2], words2[3]);
    endtask

    task automatic test_reset_mid_load();
        mode = 1'b1;
        step();
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11); send_byte(8'h55);
        reset = 1'b1;
        mode  = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({bus.load_done, bus.load_count, bus.inst_valid} !== {1'b0, 15'd0, 1'b0}) begin
            errors++;
            $display("FAIL midload_reset got done=%b cnt=%0d v=%b want done=0 cnt=0 v=0",
                     bus.load_done, bus.load_count, bus.inst_valid);
        end
        fetch(32'd0);
        checks++;
        if (bus.instruction !== 32'h11223344) begin
            errors++;
            $display("FAIL midload_word0 got %h want 11223344", bus.instruction);
        end
        fetch(32'd4);
        checks++;
        if (bus.instruction !== 32'h89abcdef) begin
            errors++;
            $display("FAIL midload_word1_kept got %h want 89abcdef", bus.instruction);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        mode = 1'b0;
        step();
        test_back_to_back(words1[0], words1[1], words1[2], words1[3]);
        test_fault();
        test_partial_abort();
        test_ignored_inputs();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Parametrised program (instruction) memory that generalises the fixed single-port program ROM into a loadable store. It has two modes. Run mode serves registered instruction fetches addressed by the byte PC. Load mode assembles a little-endian byte stream (from the UART receiver) into 32-bit words and writes them sequentially from word 0. It sits between the UART RX front end, the mode switch, and the CPU fetch stage.

Parameters:
ADDR_WIDTH, 14, word-address bits; memory depth = 2^ADDR_WIDTH words.
LOAD_WORDS, 16384, words written before a load completes; legal range 1..2^ADDR_WIDTH.
DATA_WIDTH, 32, instruction width; must be a multiple of 8 (BYTES = DATA_WIDTH/8).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
mode  input  1  0 = run (fetch), 1 = load
fetch_en  input  1  fetch request, run mode only
pc  input  32  byte address of the requested instruction
instruction  output  DATA_WIDTH  registered fetch data
inst_valid  output  1  instruction holds data for the previous-cycle request
fault  output  1  previous request was misaligned or out of range
rx_byte  input  8  load data byte
rx_valid  input  1  one-cycle strobe, rx_byte valid
load_done  output  1  LOAD_WORDS words written
load_count  output  ADDR_WIDTH+1  words written in the current or last load

Behaviour:
- Reset: instruction=0, inst_valid=0, fault=0, load_done=0, load_count=0, byte counter=0, state=IDLE. Memory contents are not cleared.
- FSM states are IDLE, LOAD, DONE.
  - IDLE→LOAD when mode=1. Entry clears load_count, the byte counter, and load_done.
  - LOAD→DONE on the write of word LOAD_WORDS-1.
  - LOAD→IDLE or DONE→IDLE when mode=0.
  - DONE stays DONE while mode=1.
- Run mode (state IDLE, mode=0):
  - If fetch_en=1 at edge N, then at edge N+1: instruction = mem[pc[ADDR_WIDTH+1:2]] and inst_valid=1. Latency is 1 cycle.
  - If fetch_en=0, inst_valid=0 at the next edge and instruction holds its last value.
  - Back-to-back fetches give one result per cycle.
  - fault=1 alongside inst_valid when pc[1:0]≠0 or pc[31:ADDR_WIDTH+2]≠0. In that case instruction=0 and the memory is not read.
- Load mode (state LOAD):
  - Each rx_valid places rx_byte into byte lane byte_cnt; lane 0 is bits 7:0 (little-endian). byte_cnt then increments.
  - On the BYTES-th byte the full word is written to mem[load_count] in that same edge, load_count increments, and byte_cnt returns to 0.
  - load_done=1 from the edge that writes the last word. It stays set until LOAD is re-entered or reset occurs.
- Ignored inputs:
  - rx_valid is ignored in IDLE and DONE, including extra bytes after completion.
  - fetch_en is ignored while mode=1, and inst_valid is forced to 0.
- Mode transitions:
  - Mode 1→0 mid-word: the partial word is discarded. Previously written words are kept. load_count keeps its value, and load_done stays 0.
  - Mode change and fetch_en in the same cycle: the mode sampled at that edge governs.
- Reset mid-load: aborts immediately to IDLE. Words already written remain in memory.
- load_count saturates at LOAD_WORDS.

Test Plan:
- Reset → all outputs 0. Assert reset during LOAD after 5 bytes → state IDLE, load_count=0, word 0 still holds its written value.
- Load LOAD_WORDS=4 with bytes 0x13,0x00,0x00,0x00, 0x93,0x00,0x10,0x00, then two more words → load_count=4, load_done=1 on the 16th byte edge, mem[0]=0x00000013, mem[1]=0x00100093.
- After load, mode=0, fetch pc=0,4,8,12 on consecutive cycles → instruction one cycle later each time = the loaded words, inst_valid=1 for 4 cycles, fault=0.
- Fetch pc=0x2 and pc=0x0001_0000 (ADDR_WIDTH=14) → inst_valid=1, fault=1, instruction=0.
- Enter load, send 6 bytes, drop mode → mem[0] written, mem[1] unchanged, load_count=1, load_done=0. Re-enter load → load_count=0 and the next word lands at mem[0].
- 3 extra rx_valid bytes in DONE, plus rx_valid in IDLE → no memory change, load_count stays 4.
